// File: rtl/winc_top_generator.sv
// winc_top_generator: AXI-side holding registers, round-robin arbiter and push logic for the top command FIFO
module winc_top_generator #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int ID_WIDTH   = 4,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int CMD_WIDTH  = 1 + ID_WIDTH + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH
) (
    input  logic                  AXI_clk,
    input  logic                  AXI_rstn,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic                  wfull_top,
    output logic                  winc_top,
    output logic [CMD_WIDTH-1:0]  wdata_top
);
    logic                  r_aw_full;
    logic                  r_w_full;
    logic                  r_ar_full;
    logic [ID_WIDTH-1:0]   r_awid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [ID_WIDTH-1:0]   r_arid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_prio_rd;
    logic                  w_wr_cand;
    logic                  w_rd_cand;
    logic                  w_both;
    logic                  w_grant_rd;
    logic                  w_push;
    logic                  w_push_wr;
    logic                  w_push_rd;

    assign awready    = !r_aw_full;
    assign wready     = !r_w_full;
    assign arready    = !r_ar_full;
    assign w_wr_cand  = r_aw_full && r_w_full;
    assign w_rd_cand  = r_ar_full;
    assign w_both     = w_wr_cand && w_rd_cand;
    // r_prio_rd selects the contention winner; a lone candidate always wins
    assign w_grant_rd = w_rd_cand && (!w_wr_cand || r_prio_rd);
    assign w_push     = (w_wr_cand || w_rd_cand) && !wfull_top;
    assign w_push_wr  = w_push && !w_grant_rd;
    assign w_push_rd  = w_push && w_grant_rd;
    assign winc_top   = w_push;

    // Command word is forced to zero whenever nothing is being pushed
    always_comb begin
        wdata_top = '0;
        if (w_push)
            wdata_top = w_grant_rd ? {1'b0, r_arid, r_araddr, {DATA_WIDTH{1'b0}}, {STRB_WIDTH{1'b0}}}
                                   : {1'b1, r_awid, r_awaddr, r_wdata, r_wstrb};
    end

    // AW holding register: capture on handshake, release when the write is pushed
    always_ff @(posedge AXI_clk or negedge AXI_rstn) begin
        if (!AXI_rstn) begin
            r_aw_full <= 1'b0;
            r_awid    <= '0;
            r_awaddr  <= '0;
        end else if (w_push_wr) begin
            r_aw_full <= 1'b0;
        end else if (awvalid && awready) begin
            r_aw_full <= 1'b1;
            r_awid    <= awid;
            r_awaddr  <= awaddr;
        end
    end

    // W holding register: loads independently of AW, released together with it
    always_ff @(posedge AXI_clk or negedge AXI_rstn) begin
        if (!AXI_rstn) begin
            r_w_full <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_push_wr) begin
            r_w_full <= 1'b0;
        end else if (wvalid && wready) begin
            r_w_full <= 1'b1;
            r_wdata  <= wdata;
            r_wstrb  <= wstrb;
        end
    end

    // AR holding register: capture on handshake, release when the read is pushed
    always_ff @(posedge AXI_clk or negedge AXI_rstn) begin
        if (!AXI_rstn) begin
            r_ar_full <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
        end else if (w_push_rd) begin
            r_ar_full <= 1'b0;
        end else if (arvalid && arready) begin
            r_ar_full <= 1'b1;
            r_arid    <= arid;
            r_araddr  <= araddr;
        end
    end

    // Round-robin pointer: after a contended push the loser gets priority next time
    always_ff @(posedge AXI_clk or negedge AXI_rstn) begin
        if (!AXI_rstn)
            r_prio_rd <= 1'b0;
        else if (w_push && w_both)
            r_prio_rd <= !w_grant_rd;
    end
endmodule

// File: tb/tb_winc_top_generator.sv
// tb_winc_top_generator: directed vector table plus hand-written stall, ordering and reset sequences
module tb_winc_top_generator;
    localparam int CMD_W = 73;

    typedef struct {
        logic             awv;
        logic [3:0]       awid;
        logic [31:0]      awaddr;
        logic             wv;
        logic [31:0]      wdata;
        logic [3:0]       wstrb;
        logic             arv;
        logic [3:0]       arid;
        logic [31:0]      araddr;
        logic             full;
        logic [2:0]       rdy;
        logic             winc;
        logic [CMD_W-1:0] cmd;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [3:0]       awid;
    logic [31:0]      awaddr;
    logic             awvalid;
    logic             awready;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             wvalid;
    logic             wready;
    logic [3:0]       arid;
    logic [31:0]      araddr;
    logic             arvalid;
    logic             arready;
    logic             wfull_top;
    logic             winc_top;
    logic [CMD_W-1:0] wdata_top;

    int n_chk  = 0;
    int n_pass = 0;
    vec_t tv[19];

    winc_top_generator dut (
        .AXI_clk   (clk),
        .AXI_rstn  (rst_n),
        .awid      (awid),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .arid      (arid),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .wfull_top (wfull_top),
        .winc_top  (winc_top),
        .wdata_top (wdata_top)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CMD_W-1:0] wcmd(input logic [3:0] id, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] s);
        return {1'b1, id, a, d, s};
    endfunction

    function automatic logic [CMD_W-1:0] rcmd(input logic [3:0] id, input logic [31:0] a);
        return {1'b0, id, a, 32'h0, 4'h0};
    endfunction

    function automatic vec_t mkv(input logic awv, input logic [3:0] awi, input logic [31:0] awa,
                                 input logic wv, input logic [31:0] wd, input logic [3:0] ws,
                                 input logic arv, input logic [3:0] ari, input logic [31:0] ara,
                                 input logic full, input logic [2:0] rdy, input logic winc,
                                 input logic [CMD_W-1:0] cmd);
        vec_t v;
        v.awv = awv; v.awid = awi; v.awaddr = awa;
        v.wv = wv; v.wdata = wd; v.wstrb = ws;
        v.arv = arv; v.arid = ari; v.araddr = ara;
        v.full = full; v.rdy = rdy; v.winc = winc; v.cmd = cmd;
        return v;
    endfunction

    function automatic vec_t idle(input logic full, input logic [2:0] rdy, input logic winc,
                                  input logic [CMD_W-1:0] cmd);
        return mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, full, rdy, winc, cmd);
    endfunction

    task automatic chk(input string nm, input logic [CMD_W-1:0] act, input logic [CMD_W-1:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk_out(input string nm, input logic [2:0] rdy, input logic winc);
        chk({nm, ".awready"}, CMD_W'(awready), CMD_W'(rdy[2]));
        chk({nm, ".wready"}, CMD_W'(wready), CMD_W'(rdy[1]));
        chk({nm, ".arready"}, CMD_W'(arready), CMD_W'(rdy[0]));
        chk({nm, ".winc_top"}, CMD_W'(winc_top), CMD_W'(winc));
    endtask

    task automatic apply(input vec_t v, input string nm);
        awvalid = v.awv; awid = v.awid; awaddr = v.awaddr;
        wvalid = v.wv; wdata = v.wdata; wstrb = v.wstrb;
        arvalid = v.arv; arid = v.arid; araddr = v.araddr;
        wfull_top = v.full;
        #2;
        chk_out(nm, v.rdy, v.winc);
        if (v.winc)
            chk({nm, ".wdata_top"}, wdata_top, v.cmd);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        awvalid = 0; awid = 0; awaddr = 0;
        wvalid = 0; wdata = 0; wstrb = 0;
        arvalid = 0; arid = 0; araddr = 0;
        wfull_top = 0;

        tv[0]  = mkv(1, 4'h3, 32'h1A10_0004, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0);
        tv[1]  = idle(0, 3'b011, 0, 0);
        tv[2]  = mkv(0, 0, 0, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 3'b011, 0, 0);
        tv[3]  = idle(0, 3'b001, 1, wcmd(4'h3, 32'h1A10_0004, 32'hDEAD_BEEF, 4'hF));
        tv[4]  = idle(0, 3'b111, 0, 0);
        tv[5]  = mkv(0, 0, 0, 0, 0, 0, 1, 4'h5, 32'h1A10_1000, 0, 3'b111, 0, 0);
        tv[6]  = idle(0, 3'b110, 1, rcmd(4'h5, 32'h1A10_1000));
        tv[7]  = idle(0, 3'b111, 0, 0);
        tv[8]  = mkv(1, 4'h1, 32'h100, 1, 32'h1111_1111, 4'h3, 1, 4'h2, 32'h200, 0, 3'b111, 0, 0);
        tv[9]  = idle(0, 3'b000, 1, wcmd(4'h1, 32'h100, 32'h1111_1111, 4'h3));
        tv[10] = idle(0, 3'b110, 1, rcmd(4'h2, 32'h200));
        tv[11] = mkv(1, 4'h6, 32'h300, 1, 32'h2222_2222, 4'hC, 1, 4'h7, 32'h400, 0, 3'b111, 0, 0);
        tv[12] = idle(0, 3'b000, 1, rcmd(4'h7, 32'h400));
        tv[13] = idle(0, 3'b001, 1, wcmd(4'h6, 32'h300, 32'h2222_2222, 4'hC));
        tv[14] = idle(0, 3'b111, 0, 0);
        tv[15] = mkv(1, 4'h8, 32'h500, 1, 32'h3333_3333, 4'h1, 1, 4'h9, 32'h600, 0, 3'b111, 0, 0);
        tv[16] = idle(0, 3'b000, 1, wcmd(4'h8, 32'h500, 32'h3333_3333, 4'h1));
        tv[17] = idle(0, 3'b110, 1, rcmd(4'h9, 32'h600));
        tv[18] = idle(0, 3'b111, 0, 0);

        @(negedge clk);
        #2;
        chk_out("reset", 3'b111, 0);
        chk("reset.wdata_top", wdata_top, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++)
            apply(tv[i], $sformatf("vec%0d", i));

        // Full stall: write held for 10 cycles, new AW offered but must be refused
        apply(mkv(1, 4'hA, 32'h1A10_0008, 1, 32'hCAFE_F00D, 4'h5, 0, 0, 0, 1, 3'b111, 0, 0), "full.load");
        for (int i = 0; i < 10; i++)
            apply(mkv(1, 4'h1, 32'hBAD0_0000, 0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0), $sformatf("full.stall%0d", i));
        apply(idle(0, 3'b001, 1, wcmd(4'hA, 32'h1A10_0008, 32'hCAFE_F00D, 4'h5)), "full.push");
        apply(idle(0, 3'b111, 0, 0), "full.after");

        // W arrives three cycles ahead of AW
        apply(mkv(0, 0, 0, 1, 32'h5A5A_5A5A, 4'h9, 0, 0, 0, 0, 3'b111, 0, 0), "wfirst.w");
        apply(mkv(0, 0, 0, 1, 32'h5A5A_5A5A, 4'h9, 0, 0, 0, 0, 3'b101, 0, 0), "wfirst.wait1");
        apply(mkv(0, 0, 0, 1, 32'h5A5A_5A5A, 4'h9, 0, 0, 0, 0, 3'b101, 0, 0), "wfirst.wait2");
        apply(mkv(1, 4'hE, 32'h40, 0, 0, 0, 0, 0, 0, 0, 3'b101, 0, 0), "wfirst.aw");
        apply(idle(0, 3'b001, 1, wcmd(4'hE, 32'h40, 32'h5A5A_5A5A, 4'h9)), "wfirst.push");
        apply(idle(0, 3'b111, 0, 0), "wfirst.after");

        // Reset in the middle of a stalled read and write
        apply(mkv(1, 4'h2, 32'h80, 1, 32'h1234_5678, 4'hF, 1, 4'h3, 32'h77, 1, 3'b111, 0, 0), "rst.load");
        awvalid = 0; wvalid = 0;
        #2;
        chk_out("rst.pending", 3'b000, 0);
        rst_n = 1'b0;
        #1;
        chk_out("rst.async", 3'b111, 0);
        chk("rst.wdata_top", wdata_top, '0);
        @(negedge clk);
        #2;
        chk_out("rst.held", 3'b111, 0);
        @(negedge clk);
        arvalid = 0;
        wfull_top = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            apply(idle(0, 3'b111, 0, 0), $sformatf("rst.nostale%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
